// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable data width, run-time parity, 1/2 stop bits,
// framing/parity error and break detection. Word and flags are registered together with data_valid.
module uart_rx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int SAMPLE_CONST = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CW = $clog2(SAMPLE_CONST);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] N   = CW'(SAMPLE_CONST - 1);
  localparam logic [CW-1:0] MID = CW'(SAMPLE_CONST / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_en_q, par_odd_q, two_stop_q;
  logic                   par_bit, perr_acc, fe_acc, stop1_low, stop_idx;
  logic                   wait_high;
  logic                   sample, mid_hit, last_bit, last_stop;
  logic                   frame_start, frame_done;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  assign sample    = baud_tick && (cnt == N);
  assign mid_hit   = baud_tick && (cnt == MID);
  assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop = !two_stop_q || stop_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!rx_s && !wait_high) state_nx = S_START;
      S_START:  if (mid_hit) state_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (sample && last_bit) state_nx = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (sample) state_nx = S_STOP;
      S_STOP:   if (sample && last_stop) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy        = (state != S_IDLE);
    frame_start = (state == S_IDLE) && (state_nx == S_START);
    frame_done  = (state == S_STOP) && sample && last_stop;
  end

  // Tick counter: START waits half a bit, every later bit waits a full bit period.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) begin
      cnt <= '0;
    end else if (baud_tick) begin
      if ((state == S_START) ? (cnt == MID) : (cnt == N)) cnt <= '0;
      else                                                cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      par_bit    <= 1'b0;
      perr_acc   <= 1'b0;
      fe_acc     <= 1'b0;
      stop1_low  <= 1'b0;
      stop_idx   <= 1'b0;
    end else if (frame_start) begin
      bit_cnt    <= '0;
      par_en_q   <= parity_en;
      par_odd_q  <= parity_odd;
      two_stop_q <= two_stop;
      par_bit    <= 1'b0;
      perr_acc   <= 1'b0;
      fe_acc     <= 1'b0;
      stop1_low  <= 1'b0;
      stop_idx   <= 1'b0;
    end else if (sample) begin
      case (state)
        S_DATA: begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BW'(1);
        end
        S_PARITY: begin
          par_bit  <= rx_s;
          perr_acc <= ((^shreg) ^ rx_s) != par_odd_q;
        end
        S_STOP: begin
          if (!stop_idx) stop1_low <= !rx_s;
          fe_acc   <= fe_acc | !rx_s;
          stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers update only alongside data_valid and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      data_valid <= frame_done;
      if (frame_done) begin
        data       <= shreg;
        parity_err <= perr_acc;
        frame_err  <= fe_acc | !rx_s;
        break_det  <= (shreg == '0) && !par_bit && (stop_idx ? stop1_low : !rx_s);
      end
    end
  end

  // A frame ending on a low line must not re-trigger until the line has risen again.
  always_ff @(posedge clk) begin
    if (rst)                       wait_high <= 1'b0;
    else if (frame_done && !rx_s)  wait_high <= 1'b1;
    else if (rx_s)                 wait_high <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames, frame-level reference model, per-cycle compare and hold checks.
module tb_uart_rx_cfg;

  localparam int DB = 8;
  localparam int SC = 16;
  localparam int SS = 2;
  localparam int EW = DB + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          baud_tick = 1'b0;
  logic          rx = 1'b1;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          two_stop = 1'b0;
  logic [DB-1:0] data;
  logic          data_valid, parity_err, frame_err, break_det, busy;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_out = '0;
  int            checks = 0;
  int            errors = 0;
  int            n_valid = 0;
  logic          busy_seen = 1'b0;

  uart_rx_cfg #(.DATA_BITS(DB), .SAMPLE_CONST(SC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .data(data), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det), .busy(busy)
  );

  // Clock / reset and baud strobe (one tick every other clock)
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    baud_tick = ~baud_tick;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: result word {break, frame_err, parity_err, data}
  function automatic logic [EW-1:0] model_frame(input logic [DB-1:0] d, input logic pen,
      input logic podd, input logic pbit, input logic s1, input logic s2, input logic tstop);
    int ones;
    logic perr, fe, brk;
    ones = $countones(d) + (pen ? int'(pbit) : 0);
    perr = pen && ((ones % 2) != (podd ? 1 : 0));
    fe   = !s1 || (tstop && !s2);
    brk  = (d == '0) && (!pen || !pbit) && !s1;
    return {brk, fe, perr, d};
  endfunction

  // Driver tasks
  task automatic wait_tick();
    do @(posedge clk); while (baud_tick !== 1'b1);
    #2;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (SC) wait_tick();
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic pen, input logic podd,
      input logic pbit, input logic s1, input logic s2, input logic tstop);
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = tstop;
    exp_q.push_back(model_frame(d, pen, podd, pbit, s1, s2, tstop));
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(s1);
    if (tstop) send_bit(s2);
    send_bit(1'b1);
  endtask

  // Scoreboard: every data_valid must match the model, outputs hold otherwise
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    cur = {break_det, frame_err, parity_err, data};
    if (busy) busy_seen = 1'b1;
    if (rst) begin
      last_out = '0;
    end else if (data_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got 0x%0h expected no word", cur);
      end else begin
        check("frame", cur, exp_q.pop_front());
      end
      last_out = cur;
    end else begin
      check("hold", cur, last_out);
    end
  end

  initial begin
    int nv;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_data", data, 0);
    check("rst_flags", {data_valid, parity_err, frame_err, break_det, busy}, 0);
    #1 rst = 1'b0;
    repeat (2 * SC) wait_tick();

    // 8N1 0xA5
    send_frame(8'hA5, 0, 0, 0, 1, 1, 0);
    check("a5_delivered", exp_q.size(), 0);
    check("a5_data", data, 8'hA5);
    check("a5_flags", {parity_err, frame_err, break_det}, 0);
    check("a5_busy", busy, 0);

    // Start glitch of 5 ticks
    nv = n_valid;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (5) wait_tick();
    rx = 1'b1;
    repeat (3 * SC) wait_tick();
    check("glitch_busy_pulse", busy_seen, 1);
    check("glitch_idle", busy, 0);
    check("glitch_no_valid", n_valid, nv);

    // 8O1 0x03: parity bit 0 gives even total (error), bit 1 gives odd total (ok)
    send_frame(8'h03, 1, 1, 0, 1, 1, 0);
    check("o1_bad_data", data, 8'h03);
    check("o1_bad_perr", parity_err, 1);
    send_frame(8'h03, 1, 1, 1, 1, 1, 0);
    check("o1_good_perr", parity_err, 0);
    check("o1_delivered", exp_q.size(), 0);

    // 8N2 0x5A with second stop low
    send_frame(8'h5A, 0, 0, 0, 1, 0, 1);
    check("n2_data", data, 8'h5A);
    check("n2_fe", frame_err, 1);
    check("n2_brk", break_det, 0);

    // Break: line low for 12 bit times, no re-trigger while low
    parity_en = 0; parity_odd = 0; two_stop = 0;
    nv = n_valid;
    exp_q.push_back(model_frame('0, 0, 0, 0, 0, 0, 0));
    rx = 1'b0;
    repeat (11 * SC) wait_tick();
    check("brk_no_retrigger", busy, 0);
    repeat (SC) wait_tick();
    rx = 1'b1;
    repeat (2 * SC) wait_tick();
    check("brk_single_valid", n_valid, nv + 1);
    check("brk_word", {break_det, frame_err, parity_err, data}, {3'b110, 8'h00});

    // Reset in the middle of 0xFF, then clean 0x3C
    rx = 1'b0;
    repeat (SC) wait_tick();
    rx = 1'b1;
    repeat (3 * SC) wait_tick();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", {break_det, frame_err, parity_err, data}, 0);
    repeat (2 * SC) wait_tick();
    send_frame(8'h3C, 0, 0, 0, 1, 1, 0);
    check("c3_data", data, 8'h3C);
    check("c3_flags", {parity_err, frame_err, break_det}, 0);

    repeat (SC) wait_tick();
    check("queue_drained", exp_q.size(), 0);
    check("valid_count", n_valid, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
